// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, drives instruction memory and
// buffers {pc, instruction} pairs in a small FIFO toward decode.
module if_prefetch_queue #(
   parameter int               DEPTH    = 4,
   parameter int               ADDR_W   = 64,
   parameter int               INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic [INSTR_W-1:0]         imem_data,
   input  logic                       redirect_valid,
   input  logic [ADDR_W-1:0]          redirect_pc,
   output logic                       id_valid,
   input  logic                       id_ready,
   output logic [INSTR_W-1:0]         id_instr,
   output logic [ADDR_W-1:0]          id_pc,
   output logic [ADDR_W-1:0]          id_pc_plus4,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [ADDR_W-1:0]  fetch_pc;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   occupancy;
   logic [ADDR_W-1:0]  pc_mem    [DEPTH];
   logic [INSTR_W-1:0] instr_mem [DEPTH];
   logic               pop;
   logic               push;

   assign imem_addr = fetch_pc;
   assign count     = occupancy;

   // A redirect hides the head so decode can never consume a stale entry.
   assign id_valid    = (occupancy != '0) && !redirect_valid;
   assign id_instr    = instr_mem[rd_ptr];
   assign id_pc       = pc_mem[rd_ptr];
   assign id_pc_plus4 = pc_mem[rd_ptr] + ADDR_W'(4);

   // A full queue still fetches when the head leaves in the same cycle.
   assign pop  = id_valid && id_ready;
   assign push = !redirect_valid && ((occupancy < FULL_COUNT) || pop);

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= fetch_pc;
         instr_mem[wr_ptr] <= imem_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc  <= RESET_PC;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else if (redirect_valid) begin
         fetch_pc  <= {redirect_pc[ADDR_W-1:2], 2'b00};
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            fetch_pc <= fetch_pc + ADDR_W'(4);
            wr_ptr   <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            occupancy <= occupancy + CNT_W'(1);
         end else if (pop && !push) begin
            occupancy <= occupancy - CNT_W'(1);
         end
      end
   end

endmodule
